// File: rtl/pcie_tx_piso_if.sv
// Symbol handshake between the TX link layer (master) and the lane serializer (slave).
// s_data must stay stable from the first cycle s_valid is high until the transfer.
interface pcie_tx_piso_if #(
    parameter int DATA_W = 10
);
    logic [DATA_W-1:0] s_data;
    logic              s_valid;
    logic              s_ready;

    modport master (
        output s_data,
        output s_valid,
        input  s_ready
    );

    modport slave (
        input  s_data,
        input  s_valid,
        output s_ready
    );
endinterface

// File: rtl/pcie_tx_piso.sv
// Transmit lane serializer: shifts pre-encoded symbols out LSB first. While the link
// is up the lane never goes quiet: it sends idle filler and periodic SKP ordered sets.
module pcie_tx_piso #(
    parameter int                DATA_W       = 10,
    parameter int                SKP_INTERVAL = 1180,
    parameter logic [DATA_W-1:0] COM_SYM      = 10'h17C,
    parameter logic [DATA_W-1:0] SKP_SYM      = 10'h0BC,
    parameter logic [DATA_W-1:0] IDL_SYM      = 10'h0B9
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 link_up,
    pcie_tx_piso_if.slave        s_if,
    output logic                 tx_serial,
    output logic                 tx_elec_idle,
    output logic                 tx_sym_start,
    output logic                 skp_active
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int SYM_W = (SKP_INTERVAL > 0) ? $clog2(SKP_INTERVAL + 1) : 1;
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(DATA_W - 1);
    localparam logic [SYM_W-1:0] SYM_LIMIT = SYM_W'(SKP_INTERVAL);
    localparam bit               SKP_EN    = (SKP_INTERVAL != 0);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t            state_q,      state_d;
    logic [DATA_W-1:0] shift_q,      shift_d;
    logic [CNT_W-1:0]  bit_cnt_q,    bit_cnt_d;
    logic [DATA_W-1:0] hold_q,       hold_d;
    logic              hold_valid_q, hold_valid_d;
    logic [SYM_W-1:0]  sym_cnt_q,    sym_cnt_d;
    logic [1:0]        skp_rem_q,    skp_rem_d;
    logic              skp_active_q, skp_active_d;

    logic [DATA_W-1:0] bnd_sym;
    logic              bnd_hold_valid;
    logic [SYM_W-1:0]  bnd_sym_cnt;
    logic [1:0]        bnd_skp_rem;
    logic              bnd_skp_active;

    logic              s_ready_int;
    logic              xfer;

    assign s_ready_int = link_up && (state_q == ACTIVE) && !hold_valid_q;
    assign s_if.s_ready = s_ready_int;
    assign xfer = s_if.s_valid && s_ready_int;

    // Symbol chosen at a boundary: finish a SKP set, start one when due, else data, else idle.
    always_comb begin
        bnd_sym        = IDL_SYM;
        bnd_hold_valid = hold_valid_q;
        bnd_sym_cnt    = sym_cnt_q;
        bnd_skp_rem    = skp_rem_q;
        bnd_skp_active = 1'b0;
        if (skp_rem_q != 2'd0) begin
            bnd_sym        = SKP_SYM;
            bnd_skp_rem    = skp_rem_q - 2'd1;
            bnd_skp_active = 1'b1;
        end else if (SKP_EN && (sym_cnt_q == SYM_LIMIT)) begin
            bnd_sym        = COM_SYM;
            bnd_skp_rem    = 2'd3;
            bnd_sym_cnt    = '0;
            bnd_skp_active = 1'b1;
        end else begin
            if (hold_valid_q) begin
                bnd_sym        = hold_q;
                bnd_hold_valid = 1'b0;
            end
            if (SKP_EN) begin
                bnd_sym_cnt = sym_cnt_q + SYM_W'(1);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        sym_cnt_d    = sym_cnt_q;
        skp_rem_d    = skp_rem_q;
        skp_active_d = skp_active_q;
        case (state_q)
            IDLE: begin
                if (link_up) begin
                    state_d      = ACTIVE;
                    shift_d      = bnd_sym;
                    hold_valid_d = bnd_hold_valid;
                    sym_cnt_d    = bnd_sym_cnt;
                    skp_rem_d    = bnd_skp_rem;
                    skp_active_d = bnd_skp_active;
                    bit_cnt_d    = '0;
                end
            end
            ACTIVE: begin
                if (!link_up) begin
                    // Dropping the link abandons everything, including a pending symbol.
                    state_d      = IDLE;
                    shift_d      = '0;
                    bit_cnt_d    = '0;
                    hold_valid_d = 1'b0;
                    sym_cnt_d    = '0;
                    skp_rem_d    = 2'd0;
                    skp_active_d = 1'b0;
                end else begin
                    if (bit_cnt_q != BIT_LAST) begin
                        shift_d   = {1'b0, shift_q[DATA_W-1:1]};
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end else begin
                        shift_d      = bnd_sym;
                        hold_valid_d = bnd_hold_valid;
                        sym_cnt_d    = bnd_sym_cnt;
                        skp_rem_d    = bnd_skp_rem;
                        skp_active_d = bnd_skp_active;
                        bit_cnt_d    = '0;
                    end
                    // A transfer only happens with the holder empty, so it never races the load.
                    if (xfer) begin
                        hold_d       = s_if.s_data;
                        hold_valid_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            sym_cnt_q    <= '0;
            skp_rem_q    <= 2'd0;
            skp_active_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            sym_cnt_q    <= sym_cnt_d;
            skp_rem_q    <= skp_rem_d;
            skp_active_q <= skp_active_d;
        end
    end

    always_comb begin
        tx_serial    = 1'b0;
        tx_elec_idle = 1'b1;
        tx_sym_start = 1'b0;
        if (state_q == ACTIVE) begin
            tx_serial    = shift_q[0];
            tx_elec_idle = 1'b0;
            tx_sym_start = (bit_cnt_q == '0);
        end
    end

    assign skp_active = skp_active_q;

endmodule
